move_sequencer: RTL and testbench

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_sequencer_pkg.sv | 33 +++
 rtl/move_sequencer_cmd_fifo.sv | 51 +++++
 rtl/move_sequencer.sv | 154 +++++++++++++++
 tb/tb_move_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_sequencer_pkg.sv
// rtl/move_sequencer_pkg.sv - shared opcodes, FSM states, reset phase and step arithmetic
package move_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_FWD  = 2'b00,
    OP_BWD  = 2'b01,
    OP_HOME = 2'b10,
    OP_ZERO = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_SETTLE  = 3'd4
  } state_e;

  localparam logic [3:0]  RESET_PHASE = 4'b1100;
  localparam logic [11:0] HOME_STEPS  = 12'hFFF;
  localparam int          CMD_W       = 14;

  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

  function automatic logic [11:0] sat_sub(input logic [11:0] a, input logic [11:0] b);
    return (b > a) ? 12'd0 : (a - b);
  endfunction

endpackage

// File: rtl/move_sequencer_cmd_fifo.sv
// rtl/move_sequencer_cmd_fifo.sv - show-ahead command queue; head word visible while not empty
module cmd_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - queues move commands and sequences one stepper at a time
// with a release cycle and a coil settle period between moves.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int SETTLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [11:0] cmd_steps,
  output logic        cmd_ready,
  output logic        go_fwd,
  output logic        go_bwd,
  output logic [11:0] move_steps,
  output logic [3:0]  old_state,
  input  logic [3:0]  fwd_state,
  input  logic [3:0]  bwd_state,
  input  logic        fwd_done,
  input  logic        bwd_done,
  input  logic        boundary,
  output logic [3:0]  coil_state,
  output logic [11:0] position,
  output logic        pos_valid,
  output logic        hit_boundary,
  output logic        busy
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e            state, state_nxt;
  op_e               cur_op;
  logic [11:0]       cur_steps;
  logic [SW-1:0]     settle_cnt;
  logic [CMD_W-1:0]  head;
  logic              fifo_full, fifo_empty, pop;
  logic [CW-1:0]     fifo_count;
  logic              sel_done;
  logic [3:0]        sel_state;

  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(QDEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && !fifo_full),
    .wdata ({cmd_op, cmd_steps}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_ready = (fifo_count < CW'(QDEPTH));
  assign busy      = !((state == ST_IDLE) && fifo_empty);
  assign sel_done  = (cur_op == OP_FWD) ? fwd_done  : bwd_done;
  assign sel_state = (cur_op == OP_FWD) ? fwd_state : bwd_state;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Home always drives toward the end-stop on the backward stepper.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    go_fwd    = 1'b0;
    go_bwd    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (cur_op == OP_ZERO ||
            (cur_op != OP_HOME && cur_steps == 12'd0)) state_nxt = ST_IDLE;
        else                                         state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        go_fwd = (cur_op == OP_FWD);
        go_bwd = (cur_op != OP_FWD);
        if (sel_done) state_nxt = ST_RELEASE;
      end
      ST_RELEASE: state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_cnt == SW'(SETTLE - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_op       <= OP_FWD;
      cur_steps    <= '0;
      settle_cnt   <= '0;
      move_steps   <= '0;
      old_state    <= RESET_PHASE;
      coil_state   <= RESET_PHASE;
      position     <= '0;
      pos_valid    <= 1'b0;
      hit_boundary <= 1'b0;
    end else begin
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SW'(1) : '0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur_op    <= op_e'(head[13:12]);
            cur_steps <= head[11:0];
          end
        end
        ST_LAUNCH: begin
          move_steps   <= (cur_op == OP_HOME) ? HOME_STEPS :
                          (cur_op == OP_ZERO) ? 12'd0 : cur_steps;
          old_state    <= coil_state;
          hit_boundary <= 1'b0;
          if (cur_op == OP_ZERO) begin
            position  <= '0;
            pos_valid <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (sel_done) begin
            coil_state <= sel_state;
            if (cur_op == OP_HOME) begin
              if (boundary) begin
                position     <= '0;
                pos_valid    <= 1'b1;
                hit_boundary <= 1'b1;
              end else begin
                pos_valid    <= 1'b0;
              end
            end else if (boundary) begin
              // Stopped early on the end-stop: the step count no longer tells us where we are.
              hit_boundary <= 1'b1;
              pos_valid    <= 1'b0;
            end else if (cur_op == OP_FWD) begin
              position <= sat_add(position, cur_steps);
            end else begin
              position <= sat_sub(position, cur_steps);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - scoreboard bench: expected launches/completions queued by stimulus,
// popped and compared by a monitor on go edges.
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [11:0] cmd_steps = '0;
  logic        cmd_ready;
  logic        go_fwd, go_bwd;
  logic [11:0] move_steps;
  logic [3:0]  old_state;
  logic [3:0]  fwd_state = '0, bwd_state = '0;
  logic        fwd_done = 1'b0, bwd_done = 1'b0;
  logic        boundary = 1'b0;
  logic [3:0]  coil_state;
  logic [11:0] position;
  logic        pos_valid, hit_boundary, busy;

  always #5 clk = ~clk;

  move_sequencer #(.QDEPTH(4), .SETTLE(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_steps(cmd_steps),
    .cmd_ready(cmd_ready), .go_fwd(go_fwd), .go_bwd(go_bwd), .move_steps(move_steps),
    .old_state(old_state), .fwd_state(fwd_state), .bwd_state(bwd_state),
    .fwd_done(fwd_done), .bwd_done(bwd_done), .boundary(boundary),
    .coil_state(coil_state), .position(position), .pos_valid(pos_valid),
    .hit_boundary(hit_boundary), .busy(busy)
  );

  typedef struct { bit dir; logic [11:0] steps; logic [3:0] old; int gap; } launch_t;
  typedef struct { bit chk_pos; logic [11:0] pos; bit pv; bit hit; logic [3:0] coil; } done_t;

  launch_t lq[$];
  done_t   dq[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every go rise must match the next queued launch, every go fall the next completion.
  initial begin
    bit prev_go;
    bit cur_go;
    int low_cnt;
    launch_t l;
    done_t d;
    prev_go = 1'b0;
    low_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_go = 1'b0;
        low_cnt = 0;
      end else begin
        cur_go = go_fwd | go_bwd;
        if (cur_go && !prev_go) begin
          if (lq.size() == 0) check("unexpected_go", {go_fwd, go_bwd}, 32'd0);
          else begin
            l = lq.pop_front();
            check("launch_go_fwd", go_fwd, !l.dir);
            check("launch_go_bwd", go_bwd, l.dir);
            check("launch_move_steps", move_steps, l.steps);
            check("launch_old_state", old_state, l.old);
            check("launch_hit_cleared", hit_boundary, 0);
            if (l.gap != 0) check("launch_gap", low_cnt, l.gap);
          end
        end else if (!cur_go && prev_go) begin
          low_cnt = 1;
          if (dq.size() == 0) check("unexpected_release", dq.size(), 1);
          else begin
            d = dq.pop_front();
            if (d.chk_pos) check("done_position", position, d.pos);
            check("done_pos_valid", pos_valid, d.pv);
            check("done_hit_boundary", hit_boundary, d.hit);
            check("done_coil_state", coil_state, d.coil);
          end
        end else if (!cur_go) begin
          low_cnt++;
        end
        prev_go = cur_go;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_launch(input bit dir, input logic [11:0] steps, input logic [3:0] old,
                            input int gap);
    launch_t l;
    l.dir = dir; l.steps = steps; l.old = old; l.gap = gap;
    lq.push_back(l);
  endtask

  task automatic exp_done(input bit chk_pos, input logic [11:0] pos, input bit pv, input bit hit,
                          input logic [3:0] coil);
    done_t d;
    d.chk_pos = chk_pos; d.pos = pos; d.pv = pv; d.hit = hit; d.coil = coil;
    dq.push_back(d);
  endtask

  task automatic send(input logic [1:0] op, input logic [11:0] st, output bit acc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_steps = st;
    acc       = cmd_ready;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_go;
    for (int i = 0; i < 100; i++) begin
      if (go_fwd | go_bwd) return;
      tick();
    end
    check("go_timeout", go_fwd | go_bwd, 1);
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      tick();
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic finish(input bit dir, input logic [3:0] st, input bit bnd);
    fwd_state = dir ? ~st : st;
    bwd_state = dir ? st : ~st;
    boundary  = bnd;
    fwd_done  = !dir;
    bwd_done  = dir;
    tick();
    fwd_done = 1'b0;
    bwd_done = 1'b0;
    boundary = 1'b0;
  endtask

  task automatic move(input bit dir, input logic [3:0] st, input bit bnd, input int delay);
    wait_go();
    repeat (delay) tick();
    finish(dir, st, bnd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit accs[5];

    // Reset with a command offered during reset: it must be dropped.
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_steps = 12'd5;
    tick(); tick(); tick();
    rst = 1'b0; cmd_valid = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_go", {go_fwd, go_bwd}, 0);
    check("rst_coil_state", coil_state, 4'b1100);
    check("rst_old_state", old_state, 4'b1100);
    check("rst_move_steps", move_steps, 0);
    check("rst_position", position, 0);
    check("rst_pos_valid", pos_valid, 0);
    check("rst_hit_boundary", hit_boundary, 0);
    repeat (3) tick();
    check("rst_cmd_dropped", busy, 0);

    // Zero: trusted origin, no go.
    send(2'b11, 12'd0, acc);
    wait_idle();
    check("zero_position", position, 0);
    check("zero_pos_valid", pos_valid, 1);

    // Forward 100; a stray backward done must be ignored.
    exp_launch(0, 12'd100, 4'b1100, 0);
    exp_done(1, 12'd100, 1, 0, 4'b0110);
    send(2'b00, 12'd100, acc);
    wait_go();
    bwd_done = 1'b1; bwd_state = 4'b1111;
    tick();
    bwd_done = 1'b0;
    check("ignore_other_done", go_fwd, 1);
    repeat (5) tick();
    finish(0, 4'b0110, 0);
    wait_idle();

    // Backward 200 from 100 saturates at 0.
    exp_launch(1, 12'd200, 4'b0110, 0);
    exp_done(1, 12'd0, 1, 0, 4'b0011);
    send(2'b01, 12'd200, acc);
    move(1, 4'b0011, 0, 4);
    wait_idle();

    // Forward 300, then home hitting the end-stop 37 steps in.
    exp_launch(0, 12'd300, 4'b0011, 0);
    exp_done(1, 12'd300, 1, 0, 4'b1001);
    send(2'b00, 12'd300, acc);
    move(0, 4'b1001, 0, 3);
    wait_idle();
    exp_launch(1, 12'd4095, 4'b1001, 0);
    exp_done(1, 12'd0, 1, 1, 4'b0011);
    send(2'b10, 12'd9, acc);
    move(1, 4'b0011, 1, 37);
    wait_idle();

    // Forward 50 ends on the end-stop; the following move clears hit_boundary at launch.
    exp_launch(0, 12'd50, 4'b0011, 0);
    exp_done(0, 12'd0, 0, 1, 4'b0110);
    send(2'b00, 12'd50, acc);
    move(0, 4'b0110, 1, 2);
    wait_idle();
    exp_launch(0, 12'd10, 4'b0110, 0);
    exp_done(1, 12'd10, 0, 0, 4'b1100);
    send(2'b00, 12'd10, acc);
    move(0, 4'b1100, 0, 2);
    wait_idle();

    // Forward with zero steps: no go at all.
    send(2'b00, 12'd0, acc);
    wait_idle();
    check("zero_steps_position", position, 10);

    // Five pushes during WAIT: four fit, each later move starts 19 go-low cycles after the last.
    exp_launch(0, 12'd5, 4'b1100, 0);
    exp_done(1, 12'd15, 0, 0, 4'b0110);
    exp_launch(0, 12'd4000, 4'b0110, 19);
    exp_done(1, 12'd4015, 0, 0, 4'b0011);
    exp_launch(0, 12'd200, 4'b0011, 19);
    exp_done(1, 12'd4095, 0, 0, 4'b1001);
    exp_launch(1, 12'd1000, 4'b1001, 19);
    exp_done(1, 12'd3095, 0, 0, 4'b1100);
    exp_launch(0, 12'd7, 4'b1100, 19);
    exp_done(1, 12'd3102, 0, 0, 4'b0110);
    send(2'b00, 12'd5, acc);
    wait_go();
    send(2'b00, 12'd4000, accs[0]);
    send(2'b00, 12'd200, accs[1]);
    send(2'b01, 12'd1000, accs[2]);
    send(2'b00, 12'd7, accs[3]);
    check("queue_ready_when_full", cmd_ready, 0);
    send(2'b01, 12'd1, accs[4]);
    for (int i = 0; i < 5; i++) check($sformatf("queue_accept_%0d", i), accs[i], (i < 4));
    finish(0, 4'b0110, 0);
    move(0, 4'b0011, 0, 2);
    move(0, 4'b1001, 0, 2);
    move(1, 4'b1100, 0, 2);
    move(0, 4'b0110, 0, 2);
    wait_idle();

    // Reset mid-WAIT with a command still queued.
    send(2'b11, 12'd0, acc);
    wait_idle();
    exp_launch(0, 12'd30, 4'b0110, 0);
    exp_done(1, 12'd30, 1, 0, 4'b1001);
    send(2'b00, 12'd30, acc);
    move(0, 4'b1001, 0, 2);
    wait_idle();
    exp_launch(0, 12'd20, 4'b1001, 0);
    send(2'b00, 12'd20, acc);
    wait_go();
    send(2'b01, 12'd3, acc);
    rst = 1'b1;
    tick();
    check("midrst_go", {go_fwd, go_bwd}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_coil_state", coil_state, 4'b1100);
    check("midrst_old_state", old_state, 4'b1100);
    check("midrst_pos_valid", pos_valid, 0);
    check("midrst_position", position, 0);
    rst = 1'b0;
    repeat (40) tick();
    check("midrst_queue_flushed", busy, 0);
    check("launch_queue_drained", lq.size(), 0);
    check("done_queue_drained", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
